alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SEC, default 60, number of sec_tick pulses a ring lasts before auto-stop.
REQ-002 Parameter SNOOZE_SEC, default 300, number of sec_tick pulses in one snooze interval.
REQ-003 Parameter MAX_SNOOZE, default 3, maximum snoozes per alarm event.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sec_tick  input  1  one-cycle pulse per elapsed second.
REQ-007 hr, mins, secs  input  8 each  current time, binary; hr 1..12, mins/secs 0..59.
REQ-008 am  input  1  1 = AM, 0 = PM.
REQ-009 arm_en  input  1  level; 1 enables the alarm.
REQ-010 load  input  1  one-cycle pulse; captures ld_hr, ld_min, ld_am.
REQ-011 ld_hr, ld_min  input  8 each  new alarm time; ld_am  input  1.
REQ-012 snooze, stop  input  1 each  one-cycle user pulses.
REQ-013 buzzer  output  1  high while ringing.
REQ-014 snoozing  output  1  high while in snooze interval.
REQ-015 al_hr, al_min  output  8 each; al_am  output  1  stored alarm time.
REQ-016 snooze_left  output  2  snoozes remaining in current event.
REQ-017 load_err  output  1  one-cycle pulse on rejected load.

Function
REQ-018 States: DISARMED, ARMED, RINGING, SNOOZE; buzzer = (state==RINGING), snoozing = (state==SNOOZE), both registered/state-decoded, no combinational path from inputs.
REQ-019 match = (hr==al_hr && mins==al_min && am==al_am && secs==0); match_q registers match each cycle; trigger = match && !match_q.
REQ-020 DISARMED -> ARMED when arm_en=1.
REQ-021 ARMED -> DISARMED when arm_en=0; else -> RINGING on trigger.
REQ-022 RINGING exit priority: arm_en=0 -> DISARMED; stop -> ARMED; snooze with snooze_left>0 -> SNOOZE; RING_SEC-th sec_tick since entry -> ARMED.
REQ-023 snooze in RINGING with snooze_left=0 is ignored; state stays RINGING.
REQ-024 SNOOZE exit priority: arm_en=0 -> DISARMED; stop -> ARMED; SNOOZE_SEC-th sec_tick since entry -> RINGING; snooze pulse ignored.
REQ-025 One 16-bit second counter, cleared on every state change, incremented on sec_tick while in RINGING or SNOOZE; sec_tick in the entry cycle is not counted.
REQ-026 snooze_left set to MAX_SNOOZE on entry to ARMED or DISARMED; decremented by 1 on each RINGING -> SNOOZE transition; never wraps.
REQ-027 load accepted only in DISARMED or ARMED and only if 1<=ld_hr<=12 and ld_min<=59; accepted values appear on al_* the next cycle.
REQ-028 Rejected load (bad range or state RINGING/SNOOZE) leaves al_* unchanged and pulses load_err for exactly one cycle.
REQ-029 load in the same cycle as a trigger: trigger uses the pre-load alarm time.
REQ-030 Trigger fires at most once per matching second; re-entry to ARMED while match still holds does not re-ring.

Reset
REQ-031 On reset=1 at a clock edge: state DISARMED, al_hr=8'h0C, al_min=8'h00, al_am=1, snooze_left=MAX_SNOOZE, counter=0, match_q=0, buzzer=0, snoozing=0, load_err=0.
REQ-032 Reset overrides every other input, including mid-ring and mid-snooze.

Verification
REQ-033 load 6:30 AM, arm_en=1, time steps to 06:30:00 AM -> buzzer=1 one cycle later; holds through secs 0..59 with no stop.
REQ-034 Ringing, no inputs, 60 sec_ticks -> buzzer=0 on the cycle after the 60th, state ARMED, no re-ring while secs==0 persists.
REQ-035 Ringing, snooze x3 each followed by 300 sec_ticks -> ring resumes each time, snooze_left 2,1,0; 4th snooze ignored, buzzer stays 1.
REQ-036 Ringing, stop and snooze same cycle -> ARMED, buzzer=0, snooze_left=3.
REQ-037 load ld_hr=13 or ld_min=60, or any load while RINGING -> load_err one cycle, al_* unchanged.
REQ-038 reset asserted mid-SNOOZE -> next cycle DISARMED, al_*=12:00 AM, buzzer=0, snoozing=0.

Source files
------------

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm clock controller: arm, ring, snooze, stop and alarm-time load
module alarm_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_sec_tick,
    input  logic [7:0] i_hr,
    input  logic [7:0] i_mins,
    input  logic [7:0] i_secs,
    input  logic       i_am,
    input  logic       i_arm_en,
    input  logic       i_load,
    input  logic [7:0] i_ld_hr,
    input  logic [7:0] i_ld_min,
    input  logic       i_ld_am,
    input  logic       i_snooze,
    input  logic       i_stop,
    output logic       o_buzzer,
    output logic       o_snoozing,
    output logic [7:0] o_al_hr,
    output logic [7:0] o_al_min,
    output logic       o_al_am,
    output logic [1:0] o_snooze_left,
    output logic       o_load_err
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } state_t;

    localparam logic [15:0] RING_LAST   = 16'(RING_SEC - 1);
    localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SEC - 1);
    localparam logic [1:0]  SNZ_MAX     = 2'(MAX_SNOOZE);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_sec_cnt;
    logic        r_match_q;
    logic [7:0]  r_al_hr;
    logic [7:0]  r_al_min;
    logic        r_al_am;
    logic [1:0]  r_snooze_left;
    logic        r_load_err;

    logic w_match;
    logic w_trigger;
    logic w_ld_state_ok;
    logic w_ld_range_ok;
    logic w_ld_accept;
    logic w_state_change;
    logic w_timed;

    // Match is taken against the stored alarm, so a same-cycle load cannot affect it
    assign w_match   = (i_hr == r_al_hr) && (i_mins == r_al_min) &&
                       (i_am == r_al_am) && (i_secs == 8'd0);
    assign w_trigger = w_match && !r_match_q;

    assign w_ld_state_ok = (r_state == DISARMED) || (r_state == ARMED);
    assign w_ld_range_ok = (i_ld_hr >= 8'd1) && (i_ld_hr <= 8'd12) && (i_ld_min <= 8'd59);
    assign w_ld_accept   = i_load && w_ld_state_ok && w_ld_range_ok;

    assign w_state_change = (w_next != r_state);
    assign w_timed        = (r_state == RINGING) || (r_state == SNOOZE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            DISARMED: begin
                if (i_arm_en) w_next = ARMED;
            end
            ARMED: begin
                if (!i_arm_en)      w_next = DISARMED;
                else if (w_trigger) w_next = RINGING;
            end
            RINGING: begin
                if (!i_arm_en)                                  w_next = DISARMED;
                else if (i_stop)                                w_next = ARMED;
                else if (i_snooze && (r_snooze_left != 2'd0))   w_next = SNOOZE;
                else if (i_sec_tick && (r_sec_cnt == RING_LAST)) w_next = ARMED;
            end
            SNOOZE: begin
                if (!i_arm_en)                                    w_next = DISARMED;
                else if (i_stop)                                  w_next = ARMED;
                else if (i_sec_tick && (r_sec_cnt == SNOOZE_LAST)) w_next = RINGING;
            end
            default: w_next = DISARMED;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= DISARMED;
            r_sec_cnt     <= 16'd0;
            r_match_q     <= 1'b0;
            r_al_hr       <= 8'h0C;
            r_al_min      <= 8'h00;
            r_al_am       <= 1'b1;
            r_snooze_left <= SNZ_MAX;
            r_load_err    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_match_q <= w_match;

            // The tick seen in the transition cycle is dropped by the clear
            if (w_state_change)
                r_sec_cnt <= 16'd0;
            else if (i_sec_tick && w_timed)
                r_sec_cnt <= r_sec_cnt + 16'd1;

            if (w_state_change && ((w_next == ARMED) || (w_next == DISARMED)))
                r_snooze_left <= SNZ_MAX;
            else if ((r_state == RINGING) && (w_next == SNOOZE) && (r_snooze_left != 2'd0))
                r_snooze_left <= r_snooze_left - 2'd1;

            if (w_ld_accept) begin
                r_al_hr  <= i_ld_hr;
                r_al_min <= i_ld_min;
                r_al_am  <= i_ld_am;
            end
            r_load_err <= i_load && !w_ld_accept;
        end
    end

    assign o_buzzer      = (r_state == RINGING);
    assign o_snoozing    = (r_state == SNOOZE);
    assign o_al_hr       = r_al_hr;
    assign o_al_min      = r_al_min;
    assign o_al_am       = r_al_am;
    assign o_snooze_left = r_snooze_left;
    assign o_load_err    = r_load_err;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - directed self-checking bench for alarm_ctrl
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset, sec_tick, am, arm_en, load, ld_am, snooze, stop;
    logic [7:0] hr, mins, secs, ld_hr, ld_min;
    logic       buzzer, snoozing, al_am, load_err;
    logic [7:0] al_hr, al_min;
    logic [1:0] snooze_left;

    int n_checks = 0;
    int n_errors = 0;

    alarm_ctrl dut (
        .i_clock      (clk),
        .i_reset      (reset),
        .i_sec_tick   (sec_tick),
        .i_hr         (hr),
        .i_mins       (mins),
        .i_secs       (secs),
        .i_am         (am),
        .i_arm_en     (arm_en),
        .i_load       (load),
        .i_ld_hr      (ld_hr),
        .i_ld_min     (ld_min),
        .i_ld_am      (ld_am),
        .i_snooze     (snooze),
        .i_stop       (stop),
        .o_buzzer     (buzzer),
        .o_snoozing   (snoozing),
        .o_al_hr      (al_hr),
        .o_al_min     (al_min),
        .o_al_am      (al_am),
        .o_snooze_left(snooze_left),
        .o_load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sec_tick = 1'b1;
            step();
            sec_tick = 1'b0;
            step();
        end
    endtask

    task automatic set_time(input int h, input int m, input int s, input logic a);
        hr = 8'(h); mins = 8'(m); secs = 8'(s); am = a;
    endtask

    task automatic do_load(input int h, input int m, input logic a);
        ld_hr = 8'(h); ld_min = 8'(m); ld_am = a; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sec_tick = 1'b0; arm_en = 1'b0; load = 1'b0;
        ld_hr = 8'd0; ld_min = 8'd0; ld_am = 1'b0; snooze = 1'b0; stop = 1'b0;
        set_time(6, 29, 59, 1'b1);
        step(); step();
        check("rst_buzzer", int'(buzzer), 0);
        check("rst_snoozing", int'(snoozing), 0);
        check("rst_al_hr", int'(al_hr), 12);
        check("rst_al_min", int'(al_min), 0);
        check("rst_al_am", int'(al_am), 1);
        check("rst_snooze_left", int'(snooze_left), 3);
        check("rst_load_err", int'(load_err), 0);
        reset = 1'b0;

        // Load 6:30 AM and arm
        do_load(6, 30, 1'b1);
        check("ld_al_hr", int'(al_hr), 6);
        check("ld_al_min", int'(al_min), 30);
        check("ld_err_clear", int'(load_err), 0);
        arm_en = 1'b1;
        step();
        set_time(6, 30, 0, 1'b1);
        check("pre_trig_buzzer", int'(buzzer), 0);
        step();
        check("trig_buzzer", int'(buzzer), 1);

        // Auto-stop after the 60th tick, no re-ring while secs==0 holds
        ticks(59);
        check("ring_59_buzzer", int'(buzzer), 1);
        ticks(1);
        check("ring_60_buzzer", int'(buzzer), 0);
        check("ring_60_snooze_left", int'(snooze_left), 3);
        for (int i = 0; i < 5; i++) step();
        check("no_rering", int'(buzzer), 0);

        // Fresh event; load while ringing is rejected
        set_time(6, 30, 1, 1'b1);
        step();
        set_time(6, 30, 0, 1'b1);
        step();
        check("ring2_buzzer", int'(buzzer), 1);
        set_time(6, 30, 5, 1'b1);
        do_load(7, 0, 1'b1);
        check("ring_ld_err", int'(load_err), 1);
        check("ring_ld_al_hr", int'(al_hr), 6);
        step();
        check("ring_ld_err_1cyc", int'(load_err), 0);

        // Three snoozes, each resuming after 300 ticks
        for (int k = 0; k < 3; k++) begin
            pulse_snooze();
            check("snz_snoozing", int'(snoozing), 1);
            check("snz_buzzer", int'(buzzer), 0);
            check("snz_left", int'(snooze_left), 2 - k);
            if (k == 0) begin
                pulse_snooze();
                check("snz_in_snz_ignored", int'(snoozing), 1);
                check("snz_in_snz_left", int'(snooze_left), 2);
            end
            ticks(299);
            check("snz_299", int'(snoozing), 1);
            ticks(1);
            check("snz_resume_buzzer", int'(buzzer), 1);
            check("snz_resume_snoozing", int'(snoozing), 0);
        end
        pulse_snooze();
        check("snz4_buzzer", int'(buzzer), 1);
        check("snz4_snoozing", int'(snoozing), 0);
        check("snz4_left", int'(snooze_left), 0);

        // Stop and snooze together: stop wins
        stop = 1'b1; snooze = 1'b1;
        step();
        stop = 1'b0; snooze = 1'b0;
        check("stop_buzzer", int'(buzzer), 0);
        check("stop_snoozing", int'(snoozing), 0);
        check("stop_left", int'(snooze_left), 3);

        // Range checks on load
        do_load(13, 0, 1'b0);
        check("ld13_err", int'(load_err), 1);
        check("ld13_al_hr", int'(al_hr), 6);
        do_load(5, 60, 1'b0);
        check("ld60_err", int'(load_err), 1);
        check("ld60_al_min", int'(al_min), 30);
        do_load(0, 10, 1'b0);
        check("ld0_err", int'(load_err), 1);
        do_load(11, 59, 1'b0);
        check("ld1159_err", int'(load_err), 0);
        check("ld1159_hr", int'(al_hr), 11);
        check("ld1159_min", int'(al_min), 59);
        check("ld1159_am", int'(al_am), 0);

        // Load coinciding with trigger: old alarm time still rings
        set_time(11, 59, 0, 1'b0);
        do_load(1, 0, 1'b1);
        check("ldtrig_buzzer", int'(buzzer), 1);
        check("ldtrig_al_hr", int'(al_hr), 1);

        // arm_en low while ringing disarms
        arm_en = 1'b0;
        step();
        check("disarm_buzzer", int'(buzzer), 0);

        // Re-ring, snooze, then reset mid-snooze
        arm_en = 1'b1;
        step();
        set_time(1, 0, 0, 1'b1);
        step();
        check("ring3_buzzer", int'(buzzer), 1);
        pulse_snooze();
        ticks(10);
        check("pre_rst_snoozing", int'(snoozing), 1);
        reset = 1'b1; stop = 1'b1; snooze = 1'b1; sec_tick = 1'b1;
        step();
        reset = 1'b0; stop = 1'b0; snooze = 1'b0; sec_tick = 1'b0; arm_en = 1'b0;
        check("midsnz_rst_snoozing", int'(snoozing), 0);
        check("midsnz_rst_buzzer", int'(buzzer), 0);
        check("midsnz_rst_al_hr", int'(al_hr), 12);
        check("midsnz_rst_al_min", int'(al_min), 0);
        check("midsnz_rst_al_am", int'(al_am), 1);
        check("midsnz_rst_left", int'(snooze_left), 3);

        // Arming while the match already holds must not ring
        set_time(12, 0, 0, 1'b1);
        step();
        arm_en = 1'b1;
        step(); step(); step();
        check("arm_during_match", int'(buzzer), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
